// File: rtl/result_fifo_reader.sv
// -----------------------------------------------------------------------------
// result_fifo_reader
//
// Read-side consumer of the pulse sequencer's result stream. Each rising edge
// of result_wr_req captures one result word into an internal FIFO. The FIFO is
// drained towards the AXI-facing bus logic through a valid/ready handshake in
// first-word-fall-through style. Occupancy, a sticky overflow flag and a
// saturating dropped-word count are reported for software diagnostics.
//
// Ports:
//   clock           system clock
//   reset           asynchronous, active-high reset
//   init            synchronous flush at the start of a sequence
//   result_data     result word, sampled in the cycle result_wr_req rises
//   result_wr_req   write request, one word per rising edge
//   bus_data        head-of-FIFO word (0 while nothing is available)
//   bus_data_valid  head word available
//   bus_data_ready  bus consumer accepts the head word
//   fifo_count      stored entries, 0..DEPTH
//   fifo_empty      fifo_count == 0
//   fifo_full       fifo_count == DEPTH
//   overflow        sticky, a word was dropped because the FIFO was full
//   drop_count      number of dropped words, saturating at 16'hFFFF
//
// Optional feature, macro RESULT_FIFO_TIMESTAMP_EN:
//   A free-running 32-bit cycle counter is stored with every word. Each entry
//   is emitted as two bus words, data first and timestamp second, and the
//   entry only leaves the FIFO on the handshake of the timestamp word.
//   This mode requires RESULT_WIDTH == 32.
// -----------------------------------------------------------------------------
module result_fifo_reader #(
  parameter int RESULT_WIDTH = 32,
  parameter int DEPTH        = 16,
  parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    init,
  input  logic [RESULT_WIDTH-1:0] result_data,
  input  logic                    result_wr_req,
  output logic [RESULT_WIDTH-1:0] bus_data,
  output logic                    bus_data_valid,
  input  logic                    bus_data_ready,
  output logic [CNT_WIDTH-1:0]    fifo_count,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic                    overflow,
  output logic [15:0]             drop_count
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

`ifdef RESULT_FIFO_TIMESTAMP_EN
  localparam int ENTRY_WIDTH = RESULT_WIDTH + 32;
`else
  localparam int ENTRY_WIDTH = RESULT_WIDTH;
`endif

  logic                   req_d;
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [ENTRY_WIDTH-1:0] head_entry;
  logic [ENTRY_WIDTH-1:0] wr_entry;

  logic push;
  logic handshake;
  logic pop_entry;
  logic push_accept;
  logic push_drop;

  // Edge detect: a request held high for several cycles yields one push.
  assign push = result_wr_req & ~req_d;

  // Full/empty come from the occupancy counter so pointer wrap is harmless.
  assign fifo_empty     = (fifo_count == '0);
  assign fifo_full      = (fifo_count == CNT_WIDTH'(DEPTH));
  assign bus_data_valid = ~fifo_empty;
  assign handshake      = bus_data_valid & bus_data_ready;

  // The head is read through the registered read pointer, so a write in the
  // same cycle never disturbs the word currently on the bus.
  assign head_entry = mem[rd_ptr];

  // When full, a push is only accepted if an entry leaves in the same cycle.
  assign push_accept = push & (~fifo_full | pop_entry);
  assign push_drop   = push & fifo_full & ~pop_entry;

`ifdef RESULT_FIFO_TIMESTAMP_EN
  logic [31:0] timestamp;
  logic        phase;

  // phase=0 presents the data half of the head entry, phase=1 its timestamp;
  // the entry is retired only when the timestamp word is accepted.
  assign pop_entry = handshake & phase;
  assign wr_entry  = {timestamp, result_data};
  assign bus_data  = ~bus_data_valid ? '0 :
                     (phase ? head_entry[ENTRY_WIDTH-1:RESULT_WIDTH]
                            : head_entry[RESULT_WIDTH-1:0]);

  // Free-running cycle counter and output phase, both restarted by init.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timestamp <= '0;
      phase     <= 1'b0;
    end else if (init) begin
      timestamp <= '0;
      phase     <= 1'b0;
    end else begin
      timestamp <= timestamp + 32'd1;
      if (handshake) begin
        phase <= ~phase;
      end
    end
  end
`else
  assign pop_entry = handshake;
  assign wr_entry  = result_data;
  assign bus_data  = bus_data_valid ? head_entry : '0;
`endif

  // Storage array: no reset, contents are only meaningful below fifo_count.
  always_ff @(posedge clock) begin
    if (push_accept && !init) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers, occupancy and diagnostics. init wins over any push or pop in
  // the same cycle, but req_d keeps sampling so a request already high
  // during init does not produce a push once init falls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_d      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      req_d <= result_wr_req;
      if (init) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        overflow   <= 1'b0;
        drop_count <= '0;
      end else begin
        if (push_accept) begin
          wr_ptr <= wr_ptr + PTR_WIDTH'(1);
        end
        if (pop_entry) begin
          rd_ptr <= rd_ptr + PTR_WIDTH'(1);
        end
        if (push_accept && !pop_entry) begin
          fifo_count <= fifo_count + CNT_WIDTH'(1);
        end else if (!push_accept && pop_entry) begin
          fifo_count <= fifo_count - CNT_WIDTH'(1);
        end
        if (push_drop) begin
          overflow <= 1'b1;
          if (drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_result_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_result_fifo_reader
//
// Self-checking bench for result_fifo_reader. A queue-based reference model
// tracks what the FIFO should hold; every cycle the DUT outputs are compared
// with the model at the falling clock edge, directed scenarios exercise the
// corner cases, and a randomized phase mixes pushes, backpressure, init and
// a mid-run reset. Honours RESULT_FIFO_TIMESTAMP_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_result_fifo_reader;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        init = 1'b0;
  logic [31:0] result_data = '0;
  logic        result_wr_req = 1'b0;
  logic [31:0] bus_data;
  logic        bus_data_valid;
  logic        bus_data_ready = 1'b0;
  logic [4:0]  fifo_count;
  logic        fifo_empty;
  logic        fifo_full;
  logic        overflow;
  logic [15:0] drop_count;

  int pass_count = 0;
  int total_count = 0;

  // Reference model state: queue of {timestamp, data} entries.
  logic [63:0] m_q[$];
  logic        m_req_prev = 1'b0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_drops = '0;
  logic [31:0] m_ts = '0;
  logic        m_phase = 1'b0;

  result_fifo_reader #(
    .RESULT_WIDTH(32),
    .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .init(init),
    .result_data(result_data),
    .result_wr_req(result_wr_req),
    .bus_data(bus_data),
    .bus_data_valid(bus_data_valid),
    .bus_data_ready(bus_data_ready),
    .fifo_count(fifo_count),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_count++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end else begin
      pass_count++;
    end
  endtask

  // Compare all DUT outputs with the model's view of the FIFO.
  task automatic checkAll();
    logic exp_valid;
    exp_valid = (m_q.size() != 0);
    checkOutput("valid", {31'd0, bus_data_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      checkOutput("data", bus_data, m_phase ? m_q[0][63:32] : m_q[0][31:0]);
    end
    checkOutput("count", {27'd0, fifo_count}, m_q.size());
    checkOutput("empty", {31'd0, fifo_empty}, {31'd0, m_q.size() == 0});
    checkOutput("full", {31'd0, fifo_full}, {31'd0, m_q.size() == DEPTH});
    checkOutput("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    checkOutput("drops", {16'd0, drop_count}, {16'd0, m_drops});
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic modelStep(input logic req, input logic [31:0] data,
                           input logic rdy, input logic ini);
    logic is_push;
    logic hs;
    logic pop_e;
    is_push = req && !m_req_prev;
    m_req_prev = req;
    if (ini) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_drops = '0;
      m_ts = '0;
      m_phase = 1'b0;
      return;
    end
    hs = (m_q.size() != 0) && rdy;
`ifdef RESULT_FIFO_TIMESTAMP_EN
    pop_e = hs && m_phase;
    if (hs) m_phase = !m_phase;
`else
    pop_e = hs;
`endif
    if (pop_e) void'(m_q.pop_front());
    if (is_push) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back({m_ts, data});
      end else begin
        m_ovf = 1'b1;
        if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
      end
    end
    m_ts = m_ts + 32'd1;
  endtask

  // One cycle: check outputs, drive inputs, step the model, wait a cycle.
  task automatic applyStimulus(input logic req, input logic [31:0] data,
                               input logic rdy, input logic ini);
    checkAll();
    result_wr_req = req;
    result_data = data;
    bus_data_ready = rdy;
    init = ini;
    modelStep(req, data, rdy, ini);
    @(negedge clock);
  endtask

  // One push edge followed by one idle cycle.
  task automatic pushWord(input logic [31:0] data, input logic rdy_edge,
                          input logic rdy_after);
    applyStimulus(1'b1, data, rdy_edge, 1'b0);
    applyStimulus(1'b0, data, rdy_after, 1'b0);
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic doReset();
    result_wr_req = 1'b0;
    bus_data_ready = 1'b0;
    init = 1'b0;
    result_data = '0;
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_valid", {31'd0, bus_data_valid}, 32'd0);
    checkOutput("rst_data", bus_data, 32'd0);
    checkOutput("rst_count", {27'd0, fifo_count}, 32'd0);
    checkOutput("rst_empty", {31'd0, fifo_empty}, 32'd1);
    checkOutput("rst_full", {31'd0, fifo_full}, 32'd0);
    checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("rst_drops", {16'd0, drop_count}, 32'd0);
    m_q.delete();
    m_req_prev = 1'b0;
    m_ovf = 1'b0;
    m_drops = '0;
    m_ts = '0;
    m_phase = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int rdy_pct;
    @(negedge clock);
    doReset();

    // Single pulse held high for 5 cycles produces one word.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    drain(4);
    checkOutput("pulse_count", {27'd0, fifo_count}, 32'd0);

    // Backpressure: three words stall, then drain in order.
    pushWord(32'd1, 1'b0, 1'b0);
    pushWord(32'd2, 1'b0, 1'b0);
    pushWord(32'd3, 1'b0, 1'b0);
    checkOutput("bp_peak", {27'd0, fifo_count}, 32'd3);
    checkOutput("bp_head", bus_data, 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    drain(8);

    // Overflow: 18 pushes into a 16-deep FIFO with no consumer.
    for (int i = 0; i < 18; i++) pushWord(32'h100 + i, 1'b0, 1'b0);
    checkOutput("ovf_full", {31'd0, fifo_full}, 32'd1);
    checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_drops", {16'd0, drop_count}, 32'd2);
    drain(40);

    // Init flush with overflow still set and 5 entries stored; the request
    // is high during init and must not count as a push afterwards.
    for (int i = 0; i < 5; i++) pushWord(32'h200 + i, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h2FF, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h2FF, 1'b0, 1'b0);
    checkOutput("init_count", {27'd0, fifo_count}, 32'd0);
    checkOutput("init_valid", {31'd0, bus_data_valid}, 32'd0);
    checkOutput("init_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("init_drops", {16'd0, drop_count}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    pushWord(32'h300, 1'b0, 1'b0);
    checkOutput("init_push", bus_data, 32'h300);
    drain(4);

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 16; i++) pushWord(32'h400 + i, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hAA55, 1'b1, 1'b0);
`ifndef RESULT_FIFO_TIMESTAMP_EN
    checkOutput("fullpp_count", {27'd0, fifo_count}, 32'd16);
    checkOutput("fullpp_ovf", {31'd0, overflow}, 32'd0);
`endif
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    drain(40);

`ifdef RESULT_FIFO_TIMESTAMP_EN
    // Timestamp: word pushed 10 cycles after the counter restarts.
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h12, 1'b0, 1'b0);
    checkOutput("ts_data", bus_data, 32'h12);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("ts_stamp", bus_data, 32'd10);
    checkOutput("ts_count", {27'd0, fifo_count}, 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("ts_done", {27'd0, fifo_count}, 32'd0);
`endif

    // Randomized traffic with varying consumer pressure.
    for (int blk = 0; blk < 4; blk++) begin
      rdy_pct = (blk == 0) ? 90 : (blk == 1) ? 20 : (blk == 2) ? 50 : 5;
      for (int i = 0; i < 500; i++) begin
        if (blk == 2 && i == 250) doReset();
        applyStimulus(1'($urandom_range(0, 1)), $urandom,
                      1'($urandom_range(0, 99) < rdy_pct),
                      1'($urandom_range(0, 149) == 0));
      end
    end
    drain(40);
    checkAll();

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
